// File: rtl/timer_bank.sv
// timer_bank: a bank of independent threshold timers sharing one prescaler.
// Each channel counts qualifying ticks (its enable AND the shared tick) while
// running. On reaching its threshold it pulses expired, then either reloads
// (periodic mode) or parks in DONE with finished held high (one-shot mode).
module timer_bank #(
   parameter int WIDTH      = 9,
   parameter int CHANNELS   = 4,
   parameter int PRESCALE_W = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [PRESCALE_W-1:0]     prescale,
   input  logic [CHANNELS-1:0]       en,
   input  logic [CHANNELS-1:0]       start,
   input  logic [CHANNELS-1:0]       periodic,
   input  logic [CHANNELS*WIDTH-1:0] threshold,
   output logic [CHANNELS-1:0]       finished,
   output logic [CHANNELS-1:0]       expired,
   output logic [CHANNELS-1:0]       busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [PRESCALE_W-1:0] PCNT_ZERO = {PRESCALE_W{1'b0}};
   localparam logic [PRESCALE_W-1:0] PCNT_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0]      CTR_ZERO  = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]      CTR_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [PRESCALE_W-1:0] r_pcnt;
   logic                  w_tick;
   logic [WIDTH-1:0]      w_thr      [CHANNELS];
   state_t                r_state    [CHANNELS];
   logic [WIDTH-1:0]      r_ctr      [CHANNELS];
   logic [CHANNELS-1:0]   r_finished;
   logic [CHANNELS-1:0]   r_expired;
   logic [CHANNELS-1:0]   r_busy;

   // The tick fires in the cycle the prescaler matches the live prescale value;
   // if prescale drops below pcnt the counter simply wraps before matching.
   assign w_tick = (r_pcnt == prescale);

   genvar g;
   generate
      for (g = 0; g < CHANNELS; g++) begin : g_thr
         assign w_thr[g] = threshold[g*WIDTH +: WIDTH];
      end
   endgenerate

   assign finished = r_finished;
   assign expired  = r_expired;
   assign busy     = r_busy;

   // Shared free-running prescaler, independent of any channel enable.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pcnt <= PCNT_ZERO;
      end else if (w_tick) begin
         r_pcnt <= PCNT_ZERO;
      end else begin
         r_pcnt <= r_pcnt + PCNT_ONE;
      end
   end

   // Per-channel IDLE/RUN/DONE state machines with registered status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_state[i]    <= ST_IDLE;
            r_ctr[i]      <= CTR_ZERO;
            r_finished[i] <= 1'b0;
            r_expired[i]  <= 1'b0;
            r_busy[i]     <= 1'b0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            // expired is a single-cycle pulse unless re-raised below
            r_expired[i] <= 1'b0;
            if (start[i]) begin
               // start (re)arms from any state and wins over a same-cycle tick
               r_state[i]    <= ST_RUN;
               r_ctr[i]      <= CTR_ZERO;
               r_finished[i] <= 1'b0;
               r_busy[i]     <= 1'b1;
            end else begin
               case (r_state[i])
                  ST_RUN: begin
                     if (en[i] && w_tick) begin
                        if (r_ctr[i] >= w_thr[i]) begin
                           // threshold reached: counter never increments past it
                           r_expired[i] <= 1'b1;
                           if (periodic[i]) begin
                              r_ctr[i] <= CTR_ZERO;
                           end else begin
                              r_state[i]    <= ST_DONE;
                              r_finished[i] <= 1'b1;
                              r_busy[i]     <= 1'b0;
                           end
                        end else begin
                           r_ctr[i] <= r_ctr[i] + CTR_ONE;
                        end
                     end else begin
                        r_ctr[i] <= r_ctr[i];
                     end
                  end
                  ST_IDLE: begin
                     r_state[i] <= ST_IDLE;
                  end
                  ST_DONE: begin
                     r_state[i] <= ST_DONE;
                  end
                  default: begin
                     // unreachable encoding: recover to a safe idle channel
                     r_state[i]    <= ST_IDLE;
                     r_ctr[i]      <= CTR_ZERO;
                     r_finished[i] <= 1'b0;
                     r_busy[i]     <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

endmodule
